trdb_itype_checker: RTL and testbench
=====================================

# trdb_itype_checker

Receive-side consistency checker for the E-Trace instruction-trace ingress stream. It consumes the per-block tuples (iaddr, iretire, ilastsize, itype) that the encoder-side connector produces from CVA6 commit ports. It holds each block until its successor arrives, derives the last-instruction and sequential-successor addresses, and checks the declared itype against the address actually taken. It emits one registered verdict per block plus saturating statistics, for verification benches and debug-trace sanity monitoring.

## Interface
- XLEN, default mure_pkg::XLEN: address width.
- IRETIRE_LEN, default mure_pkg::IRETIRE_LEN: width of the halfword retire count.
- CNT_W, default 32: statistics counter width.
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous, active-low reset.
- valid_i  in  1  ingress block valid.
- ready_o  out  1  ingress block accepted when valid_i && ready_o.
- iaddr_i  in  XLEN  address of first instruction in block.
- iretire_i  in  IRETIRE_LEN  halfwords retired in block.
- ilastsize_i  in  1  size of last instruction: 0 = 2 bytes, 1 = 4 bytes.
- itype_i  in  mure_pkg::ITYPE_LEN  type of last instruction (mure_pkg::itype_e).
- flush_i  in  1  discard held block (trace restart / resync).
- clear_i  in  1  synchronous clear of statistics counters.
- res_valid_o  out  1  verdict valid.
- res_ready_i  in  1  verdict consumed.
- res_iaddr_o  out  XLEN  held block start address.
- res_last_o  out  XLEN  held block last-instruction address.
- res_next_o  out  XLEN  successor block iaddr.
- res_itype_o  out  mure_pkg::ITYPE_LEN  held block itype.
- res_err_o  out  3  verdict code (mure_pkg::chk_err_e).
- cnt_blocks_o, cnt_tb_o, cnt_ntb_o, cnt_err_o  out  CNT_W each  statistics.

## Operation
- FSM states: EMPTY (no held block) and HELD.
- EMPTY + accept: store block, go HELD, no verdict.
- HELD + accept: register verdict for the held block against the new iaddr, then replace the held block with the new one. State stays HELD.
- flush_i: go EMPTY, drop the held block, no verdict. flush_i with accept in the same cycle: old block dropped, new block stored, state HELD, no verdict. flush_i does not affect a pending verdict.
- Arithmetic, modulo 2^XLEN, iretire zero-extended:
  - seq = iaddr + (iretire << 1).
  - last = seq − (ilastsize ? 4 : 2).
- Verdict codes, checked in this priority order:
  - ZERO_RET = 4: iretire == 0 and itype ∉ {EXC, INT}.
  - SIZE_OVF = 5: iretire == 1 and ilastsize == 1.
  - NTB_JUMP = 1: itype NTB and next ≠ seq.
  - TB_FALL = 2: itype TB and next == seq.
  - STD_DISC = 3: itype STD and next ≠ seq.
  - otherwise OK = 0. EXC, INT, ERET and UJ accept any next.
- Counters update on each verdict registration:
  - cnt_blocks +1.
  - cnt_tb +1 if itype TB; cnt_ntb +1 if itype NTB.
  - cnt_err +1 if code ≠ 0.
  - All counters saturate at all-ones.
  - clear_i zeroes them and wins over a same-cycle increment.

## Timing
- ready_o = !res_valid_o || res_ready_i; combinational, no dependence on valid_i.
- A verdict is registered on the clock edge that accepts the successor. res_valid_o rises the next cycle: latency 1 cycle from the successor handshake.
- Verdict outputs stay stable while res_valid_o && !res_ready_i. A verdict is never dropped or overwritten.
- A res_ready_i handshake and a new verdict in the same cycle: the new verdict replaces the old one, and res_valid_o stays 1.
- The last block before reset or flush never yields a verdict.
- Reset: state EMPTY, res_valid_o 0, all res_* outputs 0, all counters 0, ready_o 1.
- rst_ni asserted mid-stream: held block and pending verdict are discarded immediately.

## Structure
- mure_pkg gains:
  - chk_err_e: 3-bit enum OK, NTB_JUMP, TB_FALL, STD_DISC, ZERO_RET, SIZE_OVF.
  - IRETIRE_LEN, if not already present.
- itype_e encodings are reused unchanged from the package.
- One sub-module: trdb_sat_counter (width parameter; inc, clr, count), instantiated four times.
- Address arithmetic and verdict logic stay inline.

## Test plan
- STD sequence: blocks (0x1000, iretire 6, lastsize 1, STD) then (0x100C, …) → verdict with last 0x1008, next 0x100C, code OK; cnt_blocks 1.
- NTB that jumped: (0x2000, iretire 2, lastsize 1, NTB) then next 0x2100 → last 0x2000, code NTB_JUMP, cnt_ntb 1, cnt_err 1. TB with next 0x2004 → code TB_FALL.
- Exceptions and size errors:
  - (0x3000, iretire 0, EXC) then next 0x8000_0000 → code OK.
  - (0x3000, iretire 0, STD) → code ZERO_RET.
  - iretire 1 with lastsize 1 → code SIZE_OVF.
- Backpressure: res_ready_i held 0 for 5 cycles with valid_i high → ready_o 0. Verdict fields stay constant. No block is lost, and the verdict count equals blocks accepted − 1.
- Flush and reset:
  - flush_i with an accept in the same cycle → no verdict for the old block; the next accept yields a verdict for the new block.
  - rst_ni pulsed while HELD → all outputs 0, and the first block after reset yields no verdict.
- Saturation: CNT_W=4, 20 erroneous blocks → cnt_err 15. clear_i together with an increment → 0.

Source files
------------

// File: rtl/mure_pkg.sv
// mure_pkg: shared E-Trace ingress definitions.
//   XLEN, ITYPE_LEN, IRETIRE_LEN : widths of address, itype and retire count.
//   itype_e                      : instruction-type encodings of the last
//                                  instruction in a block.
//   chk_err_e                    : verdict codes of trdb_itype_checker.
package mure_pkg;

    localparam int unsigned XLEN        = 64;
    localparam int unsigned ITYPE_LEN   = 3;
    localparam int unsigned IRETIRE_LEN = 32;

    typedef enum logic [ITYPE_LEN-1:0] {
        STD  = 3'd0,  // standard / no control transfer
        EXC  = 3'd1,  // exception
        INT  = 3'd2,  // interrupt
        ERET = 3'd3,  // exception / interrupt return
        NTB  = 3'd4,  // not-taken branch
        TB   = 3'd5,  // taken branch
        UJ   = 3'd6   // uninferable jump
    } itype_e;

    typedef enum logic [2:0] {
        OK       = 3'd0,
        NTB_JUMP = 3'd1,
        TB_FALL  = 3'd2,
        STD_DISC = 3'd3,
        ZERO_RET = 3'd4,
        SIZE_OVF = 3'd5
    } chk_err_e;

endpackage

// File: rtl/trdb_sat_counter.sv
// trdb_sat_counter: saturating up-counter with synchronous clear.
//   clk_i, rst_ni : clock, asynchronous active-low reset.
//   inc_i         : increment request (ignored once all-ones is reached).
//   clr_i         : synchronous clear, takes priority over inc_i.
//   count_o       : current count.
module trdb_sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count <= '0;
        end else if (clr_i) begin
            r_count <= '0;
        end else if (inc_i && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count_o = r_count;

endmodule

// File: rtl/trdb_itype_checker.sv
// trdb_itype_checker: receive-side consistency checker for the E-Trace
// instruction-trace ingress stream.
//
// Each block (iaddr, iretire, ilastsize, itype) is held until its successor
// is accepted; the successor's iaddr is then the address actually taken
// after the held block, and the held block's declared itype is checked
// against it. One registered verdict per held block, plus saturating stats.
//
// Ports:
//   clk_i, rst_ni        : clock, asynchronous active-low reset.
//   valid_i / ready_o    : ingress block handshake.
//   iaddr_i, iretire_i,
//   ilastsize_i, itype_i : ingress block fields.
//   flush_i              : drop the held block (restart / resync).
//   clear_i              : synchronous clear of statistics counters.
//   res_valid_o/res_ready_i : verdict handshake.
//   res_iaddr_o, res_last_o, res_next_o, res_itype_o, res_err_o : verdict.
//   cnt_blocks_o, cnt_tb_o, cnt_ntb_o, cnt_err_o : saturating statistics.
module trdb_itype_checker #(
    parameter int unsigned XLEN        = mure_pkg::XLEN,
    parameter int unsigned IRETIRE_LEN = mure_pkg::IRETIRE_LEN,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           valid_i,
    output logic                           ready_o,
    input  logic [XLEN-1:0]                iaddr_i,
    input  logic [IRETIRE_LEN-1:0]         iretire_i,
    input  logic                           ilastsize_i,
    input  logic [mure_pkg::ITYPE_LEN-1:0] itype_i,
    input  logic                           flush_i,
    input  logic                           clear_i,
    output logic                           res_valid_o,
    input  logic                           res_ready_i,
    output logic [XLEN-1:0]                res_iaddr_o,
    output logic [XLEN-1:0]                res_last_o,
    output logic [XLEN-1:0]                res_next_o,
    output logic [mure_pkg::ITYPE_LEN-1:0] res_itype_o,
    output logic [2:0]                     res_err_o,
    output logic [CNT_W-1:0]               cnt_blocks_o,
    output logic [CNT_W-1:0]               cnt_tb_o,
    output logic [CNT_W-1:0]               cnt_ntb_o,
    output logic [CNT_W-1:0]               cnt_err_o
);

    import mure_pkg::*;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_HELD  = 1'b1
    } state_e;

    state_e                 r_state;

    // Held block
    logic [XLEN-1:0]        r_iaddr;
    logic [IRETIRE_LEN-1:0] r_iretire;
    logic                   r_lastsize;
    itype_e                 r_itype;

    // Registered verdict
    logic                   r_res_valid;
    logic [XLEN-1:0]        r_res_iaddr;
    logic [XLEN-1:0]        r_res_last;
    logic [XLEN-1:0]        r_res_next;
    itype_e                 r_res_itype;
    chk_err_e               r_res_err;

    logic                   w_accept;
    logic                   w_verdict;
    logic [XLEN-1:0]        w_seq;
    logic [XLEN-1:0]        w_last;
    chk_err_e               w_err;

    // A stalled verdict blocks ingress; a same-cycle consume frees the slot.
    assign ready_o   = !r_res_valid || res_ready_i;
    assign w_accept  = valid_i && ready_o;
    // A flush in the accept cycle discards the held block, so no verdict.
    assign w_verdict = w_accept && (r_state == S_HELD) && !flush_i;

    // iretire counts halfwords; wrap modulo 2^XLEN is intended.
    assign w_seq  = r_iaddr + (XLEN'(r_iretire) << 1);
    assign w_last = w_seq - (r_lastsize ? XLEN'(4) : XLEN'(2));

    // Priority: malformed block checks first, then control-flow checks.
    always_comb begin
        w_err = OK;
        if ((r_iretire == '0) && (r_itype != EXC) && (r_itype != INT)) begin
            w_err = ZERO_RET;
        end else if ((r_iretire == IRETIRE_LEN'(1)) && r_lastsize) begin
            w_err = SIZE_OVF;
        end else begin
            case (r_itype)
                NTB:     if (iaddr_i != w_seq) w_err = NTB_JUMP;
                TB:      if (iaddr_i == w_seq) w_err = TB_FALL;
                STD:     if (iaddr_i != w_seq) w_err = STD_DISC;
                default: w_err = OK;  // EXC, INT, ERET, UJ: any successor
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_EMPTY;
            r_iaddr     <= '0;
            r_iretire   <= '0;
            r_lastsize  <= 1'b0;
            r_itype     <= STD;
            r_res_valid <= 1'b0;
            r_res_iaddr <= '0;
            r_res_last  <= '0;
            r_res_next  <= '0;
            r_res_itype <= STD;
            r_res_err   <= OK;
        end else begin
            if (w_verdict) begin
                r_res_valid <= 1'b1;
                r_res_iaddr <= r_iaddr;
                r_res_last  <= w_last;
                r_res_next  <= iaddr_i;
                r_res_itype <= r_itype;
                r_res_err   <= w_err;
            end else if (res_ready_i) begin
                r_res_valid <= 1'b0;
            end

            if (flush_i) begin
                r_state <= w_accept ? S_HELD : S_EMPTY;
            end else if (w_accept) begin
                r_state <= S_HELD;
            end

            if (w_accept) begin
                r_iaddr    <= iaddr_i;
                r_iretire  <= iretire_i;
                r_lastsize <= ilastsize_i;
                r_itype    <= itype_e'(itype_i);
            end
        end
    end

    assign res_valid_o = r_res_valid;
    assign res_iaddr_o = r_res_iaddr;
    assign res_last_o  = r_res_last;
    assign res_next_o  = r_res_next;
    assign res_itype_o = r_res_itype;
    assign res_err_o   = r_res_err;

    // Statistics follow verdict registration, not verdict consumption.
    logic w_inc_tb, w_inc_ntb, w_inc_err;
    assign w_inc_tb  = w_verdict && (r_itype == TB);
    assign w_inc_ntb = w_verdict && (r_itype == NTB);
    assign w_inc_err = w_verdict && (w_err != OK);

    trdb_sat_counter #(.WIDTH(CNT_W)) u_cnt_blocks (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (w_verdict),
        .clr_i   (clear_i),
        .count_o (cnt_blocks_o)
    );

    trdb_sat_counter #(.WIDTH(CNT_W)) u_cnt_tb (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (w_inc_tb),
        .clr_i   (clear_i),
        .count_o (cnt_tb_o)
    );

    trdb_sat_counter #(.WIDTH(CNT_W)) u_cnt_ntb (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (w_inc_ntb),
        .clr_i   (clear_i),
        .count_o (cnt_ntb_o)
    );

    trdb_sat_counter #(.WIDTH(CNT_W)) u_cnt_err (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (w_inc_err),
        .clr_i   (clear_i),
        .count_o (cnt_err_o)
    );

endmodule

// File: tb/tb_trdb_itype_checker.sv
// Bench for trdb_itype_checker: directed scenarios followed by randomized
// traffic, all compared against a cycle-level reference model built from
// the block/verdict rules (held block, pending verdict, saturating stats).
module tb_trdb_itype_checker;

    localparam int unsigned XL  = mure_pkg::XLEN;
    localparam int unsigned IRL = mure_pkg::IRETIRE_LEN;
    localparam int unsigned ITL = mure_pkg::ITYPE_LEN;
    localparam int unsigned CW  = 4;
    localparam int          CMAX = (1 << CW) - 1;

    localparam logic [2:0] T_STD = 3'd0, T_EXC = 3'd1, T_INT = 3'd2,
                           T_NTB = 3'd4, T_TB  = 3'd5;

    logic           clk = 1'b0;
    logic           rst_ni = 1'b0;
    logic           valid_i = 1'b0;
    logic           ready_o;
    logic [XL-1:0]  iaddr_i = '0;
    logic [IRL-1:0] iretire_i = '0;
    logic           ilastsize_i = 1'b0;
    logic [ITL-1:0] itype_i = '0;
    logic           flush_i = 1'b0;
    logic           clear_i = 1'b0;
    logic           res_valid_o;
    logic           res_ready_i = 1'b1;
    logic [XL-1:0]  res_iaddr_o, res_last_o, res_next_o;
    logic [ITL-1:0] res_itype_o;
    logic [2:0]     res_err_o;
    logic [CW-1:0]  cnt_blocks_o, cnt_tb_o, cnt_ntb_o, cnt_err_o;

    trdb_itype_checker #(.CNT_W(CW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .iaddr_i      (iaddr_i),
        .iretire_i    (iretire_i),
        .ilastsize_i  (ilastsize_i),
        .itype_i      (itype_i),
        .flush_i      (flush_i),
        .clear_i      (clear_i),
        .res_valid_o  (res_valid_o),
        .res_ready_i  (res_ready_i),
        .res_iaddr_o  (res_iaddr_o),
        .res_last_o   (res_last_o),
        .res_next_o   (res_next_o),
        .res_itype_o  (res_itype_o),
        .res_err_o    (res_err_o),
        .cnt_blocks_o (cnt_blocks_o),
        .cnt_tb_o     (cnt_tb_o),
        .cnt_ntb_o    (cnt_ntb_o),
        .cnt_err_o    (cnt_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XL-1:0]  a;
        logic [IRL-1:0] ret;
        logic           ls;
        logic [2:0]     it;
    } blk_t;

    // Reference model state
    bit            m_held;
    blk_t          m_blk;
    bit            m_rv;
    logic [XL-1:0] m_ia, m_last, m_next;
    logic [2:0]    m_it, m_err;
    int            m_cnt [4];

    int total = 0;
    int bad   = 0;
    int acc_n = 0;
    int hs_n  = 0;

    task automatic chk(input string tag, input logic [XL-1:0] obs, input logic [XL-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [XL-1:0] seq_of(input blk_t b);
        return b.a + XL'(b.ret) + XL'(b.ret);
    endfunction

    function automatic logic [XL-1:0] last_of(input blk_t b);
        return seq_of(b) - (b.ls ? XL'(4) : XL'(2));
    endfunction

    function automatic logic [2:0] ref_code(input blk_t b, input logic [XL-1:0] nxt);
        logic [XL-1:0] s;
        s = seq_of(b);
        if (b.ret == 0 && b.it != T_EXC && b.it != T_INT) return 3'd4;
        if (b.ret == 1 && b.ls) return 3'd5;
        if (b.it == T_NTB && nxt != s) return 3'd1;
        if (b.it == T_TB && nxt == s) return 3'd2;
        if (b.it == T_STD && nxt != s) return 3'd3;
        return 3'd0;
    endfunction

    task automatic bump(input int i);
        if (m_cnt[i] < CMAX) m_cnt[i]++;
    endtask

    task automatic check_outs();
        chk("res_valid", res_valid_o, m_rv);
        chk("res_iaddr", res_iaddr_o, m_ia);
        chk("res_last", res_last_o, m_last);
        chk("res_next", res_next_o, m_next);
        chk("res_itype", res_itype_o, m_it);
        chk("res_err", res_err_o, m_err);
        chk("cnt_blocks", cnt_blocks_o, m_cnt[0]);
        chk("cnt_tb", cnt_tb_o, m_cnt[1]);
        chk("cnt_ntb", cnt_ntb_o, m_cnt[2]);
        chk("cnt_err", cnt_err_o, m_cnt[3]);
    endtask

    // One clock: check ready, advance the model with the current inputs,
    // clock the DUT, compare every output.
    task automatic cycle();
        bit   acc;
        blk_t nb;
        logic [2:0] code;
        #1;
        chk("ready_o", ready_o, !m_rv || res_ready_i);
        if (ready_o && valid_i) acc_n++;
        if (res_valid_o && res_ready_i) hs_n++;
        acc = valid_i && (!m_rv || res_ready_i);
        nb = '{iaddr_i, iretire_i, ilastsize_i, itype_i};
        if (acc && m_held && !flush_i) begin
            code   = ref_code(m_blk, iaddr_i);
            m_rv   = 1;
            m_ia   = m_blk.a;
            m_last = last_of(m_blk);
            m_next = iaddr_i;
            m_it   = m_blk.it;
            m_err  = code;
            bump(0);
            if (m_blk.it == T_TB) bump(1);
            if (m_blk.it == T_NTB) bump(2);
            if (code != 0) bump(3);
        end else if (res_ready_i) begin
            m_rv = 0;
        end
        if (clear_i) for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        if (flush_i) m_held = acc;
        else if (acc) m_held = 1;
        if (acc) m_blk = nb;
        @(posedge clk);
        #1;
        check_outs();
    endtask

    task automatic set_blk(input logic [XL-1:0] a, input int ret, input bit ls, input logic [2:0] it);
        valid_i     = 1'b1;
        iaddr_i     = a;
        iretire_i   = IRL'(ret);
        ilastsize_i = ls;
        itype_i     = it;
    endtask

    task automatic send(input logic [XL-1:0] a, input int ret, input bit ls, input logic [2:0] it);
        set_blk(a, ret, ls, it);
        cycle();
    endtask

    task automatic idle();
        valid_i = 1'b0;
        cycle();
    endtask

    task automatic do_reset();
        valid_i = 0; flush_i = 0; clear_i = 0; res_ready_i = 1;
        rst_ni = 1'b0;
        #1;
        m_held = 0; m_rv = 0; m_ia = '0; m_last = '0; m_next = '0; m_it = '0; m_err = '0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        check_outs();
        chk("rst_ready", ready_o, 1'b1);
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        do_reset();

        // Sequential STD block
        send(64'h1000, 6, 1, T_STD);
        chk("std_novd", res_valid_o, 1'b0);
        send(64'h100C, 2, 1, T_STD);
        chk("std_vld", res_valid_o, 1'b1);
        chk("std_last", res_last_o, 64'h1008);
        chk("std_next", res_next_o, 64'h100C);
        chk("std_err", res_err_o, 3'd0);
        chk("std_blocks", cnt_blocks_o, 1);

        // NTB that jumped, then TB that fell through
        do_reset();
        send(64'h2000, 2, 1, T_NTB);
        send(64'h2100, 2, 1, T_TB);
        chk("ntb_last", res_last_o, 64'h2000);
        chk("ntb_err", res_err_o, 3'd1);
        chk("ntb_cnt", cnt_ntb_o, 1);
        chk("ntb_errcnt", cnt_err_o, 1);
        send(64'h2104, 2, 1, T_STD);
        chk("tb_err", res_err_o, 3'd2);
        chk("tb_cnt", cnt_tb_o, 1);

        // Exception with zero retire, size overflow, zero retire on STD
        do_reset();
        send(64'h3000, 0, 0, T_EXC);
        send(64'h8000_0000, 1, 1, T_STD);
        chk("exc_err", res_err_o, 3'd0);
        chk("exc_next", res_next_o, 64'h8000_0000);
        send(64'h3000, 0, 0, T_STD);
        chk("sovf_err", res_err_o, 3'd5);
        send(64'h4000, 2, 1, T_STD);
        chk("zret_err", res_err_o, 3'd4);
        chk("zret_errcnt", cnt_err_o, 2);

        // Backpressure
        do_reset();
        acc_n = 0; hs_n = 0;
        send(64'hA000, 4, 1, T_STD);
        send(64'hA008, 4, 1, T_STD);
        res_ready_i = 1'b0;
        set_blk(64'hA010, 2, 0, T_UJ_val());
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("bp_ready", ready_o, 1'b0);
            chk("bp_hold", res_iaddr_o, 64'hA000);
        end
        res_ready_i = 1'b1;
        cycle();
        send(64'hB000, 3, 0, T_STD);
        send(64'hB006, 3, 0, T_NTB);
        idle(); idle(); idle();
        chk("bp_count", XL'(hs_n), XL'(acc_n - 1));

        // Flush together with accept, then flush alone
        do_reset();
        send(64'h5000, 2, 1, T_STD);
        flush_i = 1'b1;
        send(64'h6000, 2, 1, T_STD);
        flush_i = 1'b0;
        chk("fl_novd", res_valid_o, 1'b0);
        send(64'h7000, 2, 1, T_STD);
        chk("fl_vd", res_valid_o, 1'b1);
        chk("fl_iaddr", res_iaddr_o, 64'h6000);
        chk("fl_err", res_err_o, 3'd3);
        valid_i = 1'b0; flush_i = 1'b1;
        cycle();
        flush_i = 1'b0;
        send(64'h7100, 2, 1, T_STD);
        chk("fl2_novd", res_valid_o, 1'b0);

        // Reset while HELD with a pending verdict
        send(64'h9000, 2, 1, T_STD);
        chk("rh_vd", res_valid_o, 1'b1);
        do_reset();
        send(64'h9100, 2, 1, T_STD);
        chk("rh_novd", res_valid_o, 1'b0);

        // Saturation and clear priority
        do_reset();
        for (int i = 0; i < 21; i++) send(XL'(i + 1) << 16, 2, 1, T_NTB);
        chk("sat_err", cnt_err_o, 15);
        chk("sat_ntb", cnt_ntb_o, 15);
        idle();
        clear_i = 1'b1;
        send(64'hF_0000, 2, 1, T_NTB);
        clear_i = 1'b0;
        chk("clr_err", cnt_err_o, 0);
        chk("clr_blocks", cnt_blocks_o, 0);
        chk("clr_vd", res_valid_o, 1'b1);

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 800; n++) begin
            logic [XL-1:0] a;
            if (m_held && ($urandom % 2 == 0)) a = seq_of(m_blk);
            else a = {$urandom, $urandom};
            set_blk(a, int'($urandom % 5), bit'($urandom % 2), 3'($urandom % 8));
            valid_i     = ($urandom % 4) != 0;
            res_ready_i = ($urandom % 4) != 0;
            flush_i     = ($urandom % 16) == 0;
            clear_i     = ($urandom % 40) == 0;
            cycle();
            if (n == 400) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    function automatic logic [2:0] T_UJ_val();
        return 3'd6;
    endfunction

endmodule
